// File: rtl/lif_neuron_array_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : lif_pkg
//  Description : Shared constants, neuron state record and saturating adder
//                for the time-multiplexed LIF neuron array.
//  Contents    : LIF_W / LIF_RW default widths, neuron_state_t, sat_add()
//  Revision    : 1.0  initial release
// ============================================================================
package lif_pkg;

    localparam int LIF_W        = 8;   // default membrane / current width
    localparam int LIF_RW       = 3;   // default refractory counter width
    localparam int LIF_SAT_MAXW = 32;  // widest operand sat_add() accepts

    // Architectural state of one neuron at the default widths.
    typedef struct packed {
        logic [LIF_W-1:0]  v;     // membrane potential
        logic [LIF_W-1:0]  pend;  // current injected since the last update
        logic [LIF_RW-1:0] rc;    // remaining refractory updates
    } neuron_state_t;

    // Unsigned add of two 'width'-bit operands, clamped to 2^width-1.
    // Operands arrive zero-extended to LIF_SAT_MAXW; callers truncate the
    // result back to their own width, which is lossless after the clamp.
    function automatic logic [LIF_SAT_MAXW-1:0] sat_add(
        input logic [LIF_SAT_MAXW-1:0] a,
        input logic [LIF_SAT_MAXW-1:0] b,
        input int unsigned             width
    );
        logic [LIF_SAT_MAXW:0] sum;
        logic [LIF_SAT_MAXW:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = {{LIF_SAT_MAXW{1'b0}}, 1'b1};
        lim = (lim << width) - {{LIF_SAT_MAXW{1'b0}}, 1'b1};
        if (sum > lim) begin
            return lim[LIF_SAT_MAXW-1:0];
        end
        return sum[LIF_SAT_MAXW-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lif_neuron_array_if.sv
`default_nettype none
// ============================================================================
//  Interface   : lif_neuron_array_if
//  Description : Current-injection, configuration, probe and spike-output
//                bundle of the LIF neuron array.
//  Modports    : master - pad wrapper side (drives injection/config/probe)
//                slave  - neuron array side (drives vmem/spike/sweep outputs)
//  Signals     : ena, cur_valid, cur_idx, cur_in, threshold, leak_shift,
//                refrac_len, probe_idx -> array
//                vmem_out, spike_valid, spike_idx, spike_vec, sweep_done <- array
//  Revision    : 1.0  initial release
// ============================================================================
interface lif_neuron_array_if
    import lif_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = LIF_W,
    parameter int RW = LIF_RW
);
    localparam int IW = $clog2(N);

    logic          ena;
    logic          cur_valid;
    logic [IW-1:0] cur_idx;
    logic [W-1:0]  cur_in;
    logic [W-1:0]  threshold;
    logic [2:0]    leak_shift;
    logic [RW-1:0] refrac_len;
    logic [IW-1:0] probe_idx;
    logic [W-1:0]  vmem_out;
    logic          spike_valid;
    logic [IW-1:0] spike_idx;
    logic [N-1:0]  spike_vec;
    logic          sweep_done;

    modport master (
        output ena, cur_valid, cur_idx, cur_in, threshold, leak_shift,
               refrac_len, probe_idx,
        input  vmem_out, spike_valid, spike_idx, spike_vec, sweep_done
    );

    modport slave (
        input  ena, cur_valid, cur_idx, cur_in, threshold, leak_shift,
               refrac_len, probe_idx,
        output vmem_out, spike_valid, spike_idx, spike_vec, sweep_done
    );

endinterface
`default_nettype wire

// File: rtl/lif_neuron_array_update.sv
`default_nettype none
// ============================================================================
//  Module      : lif_update
//  Description : Combinational leaky integrate-and-fire step for one neuron.
//                Applies leak, adds the integrated current with saturation,
//                tests the threshold and handles the refractory countdown.
//  Ports       : v_i, rc_i          current membrane and refractory count
//                cur_i              current to integrate this update
//                threshold_i        firing threshold (0 = never fire)
//                leak_shift_i       leak = v >> leak_shift
//                refrac_len_i       refractory length loaded on a spike
//                v_next_o, rc_next_o, fire_o   next state and spike flag
//  Revision    : 1.0  initial release
// ============================================================================
module lif_update
    import lif_pkg::*;
#(
    parameter int W  = LIF_W,
    parameter int RW = LIF_RW
) (
    input  logic [W-1:0]  v_i,
    input  logic [RW-1:0] rc_i,
    input  logic [W-1:0]  cur_i,
    input  logic [W-1:0]  threshold_i,
    input  logic [2:0]    leak_shift_i,
    input  logic [RW-1:0] refrac_len_i,
    output logic [W-1:0]  v_next_o,
    output logic [RW-1:0] rc_next_o,
    output logic          fire_o
);

    logic [W-1:0] leaked;
    logic [W-1:0] v_int;

    // A shift of 0 subtracts v from itself, i.e. the membrane fully leaks.
    assign leaked = v_i - (v_i >> leak_shift_i);
    assign v_int  = W'(sat_add(LIF_SAT_MAXW'(leaked), LIF_SAT_MAXW'(cur_i), W));

    always_comb begin
        v_next_o  = v_int;
        rc_next_o = '0;
        fire_o    = 1'b0;
        if (rc_i != '0) begin
            // Refractory: membrane clamped, integrated current is dropped.
            v_next_o  = '0;
            rc_next_o = rc_i - RW'(1);
        end else if ((threshold_i != '0) && (v_int >= threshold_i)) begin
            fire_o    = 1'b1;
            v_next_o  = '0;
            rc_next_o = refrac_len_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron_array
//  Description : N leaky integrate-and-fire neurons sharing one update
//                datapath. One neuron per enabled cycle is updated in
//                round-robin order; currents may be injected into any neuron
//                in any cycle and are bypassed into a same-cycle update.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    lif_neuron_array_if.slave (injection, config, probe,
//                       spike event stream, spike vector, sweep pulse)
//  Revision    : 1.0  initial release
// ============================================================================
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = LIF_W,
    parameter int RW = LIF_RW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lif_neuron_array_if.slave       bus
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] C_LAST = IW'(N - 1);

    // Per-neuron state
    logic [W-1:0]  v_q    [N];
    logic [W-1:0]  pend_q [N];
    logic [RW-1:0] rc_q   [N];

    logic [IW-1:0] ptr_q;
    logic          spike_valid_q;
    logic [IW-1:0] spike_idx_q;
    logic [N-1:0]  spike_vec_q;
    logic          sweep_done_q;

    // Shared update datapath
    logic [W-1:0]  v_sel;
    logic [W-1:0]  pend_sel;
    logic [RW-1:0] rc_sel;
    logic [W-1:0]  cur_byp;
    logic [W-1:0]  cur_upd;
    logic [W-1:0]  v_d;
    logic [RW-1:0] rc_d;
    logic          fire;
    logic [W-1:0]  vmem;

    always_comb begin
        v_sel    = '0;
        pend_sel = '0;
        rc_sel   = '0;
        vmem     = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q == IW'(i)) begin
                v_sel    = v_q[i];
                pend_sel = pend_q[i];
                rc_sel   = rc_q[i];
            end
            if (bus.probe_idx == IW'(i)) begin
                vmem = v_q[i];
            end
        end
    end

    // An injection aimed at the neuron being updated joins this update
    // directly instead of landing in pend, which is cleared by the update.
    assign cur_byp = (bus.cur_valid && (bus.cur_idx == ptr_q)) ? bus.cur_in : '0;
    assign cur_upd = W'(sat_add(LIF_SAT_MAXW'(pend_sel), LIF_SAT_MAXW'(cur_byp), W));

    lif_update #(
        .W (W),
        .RW(RW)
    ) u_update (
        .v_i         (v_sel),
        .rc_i        (rc_sel),
        .cur_i       (cur_upd),
        .threshold_i (bus.threshold),
        .leak_shift_i(bus.leak_shift),
        .refrac_len_i(bus.refrac_len),
        .v_next_o    (v_d),
        .rc_next_o   (rc_d),
        .fire_o      (fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                v_q[i]    <= '0;
                pend_q[i] <= '0;
                rc_q[i]   <= '0;
            end
            spike_vec_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.ena && (ptr_q == IW'(i))) begin
                    v_q[i]         <= v_d;
                    rc_q[i]        <= rc_d;
                    pend_q[i]      <= '0;
                    spike_vec_q[i] <= fire;
                end else if (bus.cur_valid && (bus.cur_idx == IW'(i))) begin
                    pend_q[i] <= W'(sat_add(LIF_SAT_MAXW'(pend_q[i]),
                                            LIF_SAT_MAXW'(bus.cur_in), W));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            sweep_done_q  <= 1'b0;
        end else if (bus.ena) begin
            ptr_q         <= (ptr_q == C_LAST) ? '0 : ptr_q + IW'(1);
            spike_valid_q <= fire;
            sweep_done_q  <= (ptr_q == C_LAST);
            if (fire) begin
                spike_idx_q <= ptr_q;
            end
        end else begin
            spike_valid_q <= 1'b0;
            sweep_done_q  <= 1'b0;
        end
    end

    assign bus.vmem_out    = vmem;
    assign bus.spike_valid = spike_valid_q;
    assign bus.spike_idx   = spike_idx_q;
    assign bus.spike_vec   = spike_vec_q;
    assign bus.sweep_done  = sweep_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_neuron_array
//  Description : Self-checking bench for lif_neuron_array (N=4, W=8, RW=3).
//                Random and directed stimulus against an arithmetic model of
//                the neuron array.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lif_neuron_array;
    import lif_pkg::*;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int RW   = 3;
    localparam int VMAX = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lif_neuron_array_if #(.N(N), .W(W), .RW(RW)) ifc ();

    lif_neuron_array #(.N(N), .W(W), .RW(RW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    int checks = 0;
    int errors = 0;

    // Reference model
    neuron_state_t m [N];
    int            m_ptr;
    logic [N-1:0]  m_vec;
    logic          m_sv;
    int            m_si;
    logic          m_sd;
    int            thr, ls, rl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int x);
        return (x > VMAX) ? VMAX : x;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m[i] = '0;
        end
        m_ptr = 0;
        m_vec = '0;
        m_sv  = 1'b0;
        m_si  = 0;
        m_sd  = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit cv, input int ci, input int cin);
        int  p, cur, vn;
        bit  fired;
        p     = -1;
        fired = 1'b0;
        m_sv  = 1'b0;
        m_sd  = 1'b0;
        if (en) begin
            p   = m_ptr;
            cur = clamp(int'(m[p].pend) + ((cv && ci == p) ? cin : 0));
            m[p].pend = '0;
            if (m[p].rc != 0) begin
                m[p].v  = '0;
                m[p].rc = RW'(int'(m[p].rc) - 1);
            end else begin
                vn    = clamp(int'(m[p].v) - int'(m[p].v) / (1 << ls) + cur);
                fired = (thr != 0) && (vn >= thr);
                if (fired) begin
                    m[p].v  = '0;
                    m[p].rc = RW'(rl);
                end else begin
                    m[p].v = W'(vn);
                end
            end
            m_vec[p] = fired;
            if (fired) begin
                m_sv = 1'b1;
                m_si = p;
            end
            m_sd  = (p == N - 1);
            m_ptr = (p + 1) % N;
        end
        if (cv && ci != p) begin
            m[ci].pend = W'(clamp(int'(m[ci].pend) + cin));
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input bit en, input bit cv, input int ci, input int cin, input int probe);
        ifc.ena        = en;
        ifc.cur_valid  = cv;
        ifc.cur_idx    = 2'(ci);
        ifc.cur_in     = 8'(cin);
        ifc.threshold  = 8'(thr);
        ifc.leak_shift = 3'(ls);
        ifc.refrac_len = 3'(rl);
        ifc.probe_idx  = 2'(probe);
        model_step(en, cv, ci, cin);
        @(posedge clk);
        #1;
        chk("spike_valid", 32'(ifc.spike_valid), 32'(m_sv));
        if (m_sv) chk("spike_idx", 32'(ifc.spike_idx), 32'(m_si));
        chk("spike_vec", 32'(ifc.spike_vec), 32'(m_vec));
        chk("sweep_done", 32'(ifc.sweep_done), 32'(m_sd));
        chk("vmem_out", 32'(ifc.vmem_out), 32'(m[probe].v));
    endtask

    task automatic do_reset();
        #2;
        ifc.ena       = 1'b0;
        ifc.cur_valid = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("rst_spike_valid", 32'(ifc.spike_valid), 32'(0));
        chk("rst_spike_idx", 32'(ifc.spike_idx), 32'(0));
        chk("rst_spike_vec", 32'(ifc.spike_vec), 32'(0));
        chk("rst_sweep_done", 32'(ifc.sweep_done), 32'(0));
        for (int p = 0; p < N; p++) begin
            ifc.probe_idx = 2'(p);
            #1;
            chk("rst_vmem", 32'(ifc.vmem_out), 32'(0));
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic random_run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            thr = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            ls  = int'($urandom_range(0, 7));
            rl  = int'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, N - 1)), int'($urandom_range(0, 150)),
                 int'($urandom_range(0, N - 1)));
        end
    endtask

    int leak_exp [10] = '{200, 100, 50, 25, 13, 7, 4, 2, 1, 1};
    int spikes_seen;
    int first_spike, second_spike, cyc;
    int sweeps, enabled;

    initial begin
        thr = 0; ls = 0; rl = 0;
        ifc.cur_idx = '0; ifc.cur_in = '0; ifc.threshold = '0;
        ifc.leak_shift = '0; ifc.refrac_len = '0; ifc.probe_idx = '0;
        #1;
        do_reset();

        // Random traffic, reset mid-run, more random traffic
        random_run(150);
        do_reset();
        random_run(100);

        // Integrate and fire on neuron 2
        do_reset();
        thr = 100; ls = 7; rl = 0;
        step(1, 0, 0, 0, 2);
        step(1, 1, 2, 60, 2);
        step(1, 0, 0, 0, 2);
        chk("iaf_first_v", 32'(ifc.vmem_out), 32'(60));
        chk("iaf_first_nospike", 32'(ifc.spike_valid), 32'(0));
        step(1, 0, 0, 0, 2);
        step(1, 0, 0, 0, 2);
        step(1, 1, 2, 60, 2);
        step(1, 0, 0, 0, 2);
        chk("iaf_spike_valid", 32'(ifc.spike_valid), 32'(1));
        chk("iaf_spike_idx", 32'(ifc.spike_idx), 32'(2));
        chk("iaf_spike_vec", 32'(ifc.spike_vec), 32'(4'b0100));
        chk("iaf_vmem_after", 32'(ifc.vmem_out), 32'(0));

        // Leak decay on neuron 0
        do_reset();
        thr = 0; ls = 1; rl = 0;
        for (int s = 0; s < 10; s++) begin
            step(1, s == 0, 0, 200, 0);
            chk("leak_v", 32'(ifc.vmem_out), 32'(leak_exp[s]));
            chk("leak_nospike", 32'(ifc.spike_valid), 32'(0));
            for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
        end

        // Refractory period on neuron 1
        do_reset();
        thr = 50; ls = 7; rl = 2;
        first_spike = -1; second_spike = -1; cyc = 0;
        for (int s = 0; s < 7; s++) begin
            for (int k = 0; k < 4; k++) begin
                step(1, 1, 1, 255, 1);
                cyc++;
                if (k == 1) begin
                    chk("refr_fire", 32'(ifc.spike_valid), 32'(s % 3 == 0));
                    chk("refr_v", 32'(ifc.vmem_out), 32'(0));
                    if (ifc.spike_valid === 1'b1) begin
                        if (first_spike < 0) first_spike = cyc;
                        else if (second_spike < 0) second_spike = cyc;
                    end
                end
            end
        end
        chk("refr_period", 32'(second_spike - first_spike), 32'(3 * N));

        // Saturating accumulation while disabled, then update
        do_reset();
        thr = 0; ls = 7; rl = 0;
        step(0, 1, 3, 200, 3);
        step(0, 1, 3, 200, 3);
        step(0, 0, 0, 0, 3);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 3);
        chk("sat_v", 32'(ifc.vmem_out), 32'(255));

        // Same-cycle bypass into the slot
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 3);
        step(1, 1, 3, 10, 3);
        chk("bypass_v", 32'(ifc.vmem_out), 32'(10));

        // Sweep cadence with ena toggling
        do_reset();
        sweeps = 0; enabled = 0;
        for (int c = 0; c < 48; c++) begin
            thr = int'($urandom_range(1, 40)); ls = int'($urandom_range(0, 7)); rl = 0;
            step(c % 3 != 1, $urandom_range(0, 1) == 1, int'($urandom_range(0, N - 1)),
                 int'($urandom_range(0, 60)), int'($urandom_range(0, N - 1)));
            if (c % 3 == 1) begin
                chk("idle_no_spike", 32'(ifc.spike_valid), 32'(0));
            end else begin
                enabled++;
            end
            if (ifc.sweep_done === 1'b1) sweeps++;
        end
        chk("sweep_count", 32'(sweeps), 32'(enabled / N));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
